// File: rtl/cam_i2c_write_master.sv
// I2C write-only master for camera register programming: START, device address,
// register address, two data bytes (MSB first), STOP. Open-drain via *_oe outputs.
module cam_i2c_write_master #(
  parameter int unsigned CLK_DIV       = 125,
  parameter logic [6:0]  DEV_ADDR_CAM0 = 7'h48,
  parameter logic [6:0]  DEV_ADDR_CAM1 = 7'h49
) (
  input  logic        sysClk,
  input  logic        rst_n,
  input  logic [7:0]  cmd_addr,
  input  logic [15:0] cmd_data,
  input  logic        cmd_cam_id,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  output logic        scl_oe,
  output logic        sda_oe,
  input  logic        sda_i,
  output logic        done,
  output logic        nack_err
);

  localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, START, BYTE, ACK, STOP} state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       phase;
  logic [2:0]       bit_cnt;
  logic [1:0]       byte_cnt;
  logic [31:0]      shreg;
  logic             ack_smp;

  logic tick;
  logic nack_now;

  assign tick = (div_cnt == DIV_LAST);
  // With CLK_DIV=1 the sample cycle is also the decision cycle, so use the live line.
  assign nack_now = (div_cnt == '0) ? sda_i : ack_smp;

  // Line drive {scl_oe, sda_oe} for a given state, quarter-bit phase and data bit.
  function automatic logic [1:0] line_drive(input state_t s, input logic [1:0] q, input logic b);
    logic [1:0] d;
    d = 2'b00;
    case (s)
      START:   d = (q == 2'd3) ? 2'b11 : 2'b01;
      BYTE:    d = {~q[1], ~b};
      ACK:     d = {~q[1], 1'b0};
      STOP: begin
        case (q)
          2'd0:    d = 2'b11;
          2'd1:    d = 2'b01;
          default: d = 2'b00;
        endcase
      end
      default: d = 2'b00;
    endcase
    return d;
  endfunction

  always_ff @(posedge sysClk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      div_cnt   <= '0;
      phase     <= 2'd0;
      bit_cnt   <= 3'd0;
      byte_cnt  <= 2'd0;
      shreg     <= 32'd0;
      ack_smp   <= 1'b0;
      cmd_ready <= 1'b1;
      scl_oe    <= 1'b0;
      sda_oe    <= 1'b0;
      done      <= 1'b0;
      nack_err  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (cmd_valid) begin
          state            <= START;
          div_cnt          <= '0;
          phase            <= 2'd0;
          bit_cnt          <= 3'd0;
          byte_cnt         <= 2'd0;
          shreg            <= {(cmd_cam_id ? DEV_ADDR_CAM1 : DEV_ADDR_CAM0), 1'b0,
                               cmd_addr, cmd_data};
          nack_err         <= 1'b0;
          cmd_ready        <= 1'b0;
          {scl_oe, sda_oe} <= line_drive(START, 2'd0, 1'b0);
        end
      end else begin
        div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
        if (state == ACK && phase == 2'd3 && div_cnt == '0)
          ack_smp <= sda_i;
        if (tick) begin
          phase <= phase + 2'd1;
          if (phase != 2'd3) begin
            {scl_oe, sda_oe} <= line_drive(state, phase + 2'd1, shreg[31]);
          end else begin
            // End of a bit period: advance the protocol state.
            case (state)
              START: begin
                state            <= BYTE;
                {scl_oe, sda_oe} <= line_drive(BYTE, 2'd0, shreg[31]);
              end
              BYTE: begin
                shreg <= {shreg[30:0], 1'b0};
                if (bit_cnt == 3'd7) begin
                  bit_cnt          <= 3'd0;
                  state            <= ACK;
                  {scl_oe, sda_oe} <= line_drive(ACK, 2'd0, 1'b0);
                end else begin
                  bit_cnt          <= bit_cnt + 3'd1;
                  {scl_oe, sda_oe} <= line_drive(BYTE, 2'd0, shreg[30]);
                end
              end
              ACK: begin
                if (nack_now || byte_cnt == 2'd3) begin
                  byte_cnt         <= 2'd0;
                  nack_err         <= nack_now;
                  state            <= STOP;
                  {scl_oe, sda_oe} <= line_drive(STOP, 2'd0, 1'b0);
                end else begin
                  byte_cnt         <= byte_cnt + 2'd1;
                  state            <= BYTE;
                  {scl_oe, sda_oe} <= line_drive(BYTE, 2'd0, shreg[31]);
                end
              end
              STOP: begin
                state            <= IDLE;
                done             <= 1'b1;
                cmd_ready        <= 1'b1;
                {scl_oe, sda_oe} <= 2'b00;
              end
              default: begin
                state            <= IDLE;
                cmd_ready        <= 1'b1;
                {scl_oe, sda_oe} <= 2'b00;
              end
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cam_i2c_write_master.sv
// Directed bench for cam_i2c_write_master: decodes SCL/SDA into bytes and checks
// bytes, timing, NACK handling, back-to-back commands and mid-transaction reset.
module tb_cam_i2c_write_master;

  localparam int unsigned CLK_DIV = 4;
  localparam int          BUDGET  = 3000;

  logic        sysClk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  cmd_addr = 8'h00;
  logic [15:0] cmd_data = 16'h0000;
  logic        cmd_cam_id = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        scl_oe;
  logic        sda_oe;
  logic        sda_i;
  logic        done;
  logic        nack_err;

  int n_cmp = 0;
  int n_bad = 0;

  cam_i2c_write_master #(
    .CLK_DIV      (CLK_DIV),
    .DEV_ADDR_CAM0(7'h48),
    .DEV_ADDR_CAM1(7'h49)
  ) dut (
    .sysClk    (sysClk),
    .rst_n     (rst_n),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .cmd_cam_id(cmd_cam_id),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .scl_oe    (scl_oe),
    .sda_oe    (sda_oe),
    .sda_i     (sda_i),
    .done      (done),
    .nack_err  (nack_err)
  );

  always #5 sysClk = ~sysClk;

  // Bus decoder: SDA level captured on every SCL rising edge (scl_oe 1 -> 0).
  logic prev_scl = 1'b0;
  int   rises = 0;
  logic bitq[$];
  always @(negedge sysClk) begin
    if (prev_scl && !scl_oe) begin
      bitq.push_back(~sda_oe);
      rises = rises + 1;
    end
    prev_scl = scl_oe;
  end

  // Slave: ACKs everything except the acknowledge slot of byte nack_k.
  int base = 0;
  int nack_k = -1;
  assign sda_i = (nack_k >= 0) && (rises == base + 9 * nack_k + 9);

  typedef struct {
    logic        cam;
    logic [7:0]  addr;
    logic [15:0] data;
    int          nack_k;
    int          exp_nbytes;
    logic [31:0] exp_bytes;
    int          exp_cyc;
    logic        exp_nack;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic accept(input logic cam, input logic [7:0] a, input logic [15:0] d, input int nk);
    cmd_cam_id = cam;
    cmd_addr   = a;
    cmd_data   = d;
    cmd_valid  = 1'b1;
    check("ready_before_accept", 32'(cmd_ready), 32'(1));
    @(posedge sysClk);
    base   = rises;
    nack_k = nk;
    #1;
    cmd_valid  = 1'b0;
    cmd_cam_id = ~cam;
    cmd_addr   = ~a;
    cmd_data   = ~d;
    check("ready_after_accept", 32'(cmd_ready), 32'(0));
  endtask

  task automatic wait_done(input string tag, input int exp_cyc);
    int cyc;
    cyc = 0;
    while (cyc < BUDGET) begin
      @(posedge sysClk);
      cyc++;
      #1;
      if (done) break;
    end
    check({tag, "_done_cycle"}, 32'(cyc), 32'(exp_cyc));
  endtask

  task automatic check_bytes(input string tag, input int b0, input int nbytes, input logic [31:0] exp);
    logic [7:0] got;
    check({tag, "_scl_rises"}, 32'(rises - b0), 32'(nbytes * 9 + 1));
    for (int k = 0; k < nbytes; k++) begin
      got = 8'h00;
      for (int j = 0; j < 8; j++) got = {got[6:0], bitq[b0 + 9 * k + j]};
      check($sformatf("%s_byte%0d", tag, k), 32'(got), 32'(exp[31 - 8 * k -: 8]));
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int b0;
    accept(v.cam, v.addr, v.data, v.nack_k);
    b0 = base;
    wait_done(tag, v.exp_cyc);
    check({tag, "_nack_err"}, 32'(nack_err), 32'(v.exp_nack));
    check({tag, "_ready_at_done"}, 32'(cmd_ready), 32'(1));
    check({tag, "_lines_at_done"}, 32'({scl_oe, sda_oe}), 32'(0));
    check_bytes(tag, b0, v.exp_nbytes, v.exp_bytes);
    @(posedge sysClk);
    #1;
    check({tag, "_done_width"}, 32'(done), 32'(0));
  endtask

  initial begin
    int b0;
    int n;
    vecs[0] = '{1'b0, 8'h12, 16'hA55A, -1, 4, 32'h9012_A55A, 608, 1'b0};
    vecs[1] = '{1'b1, 8'h12, 16'hA55A, -1, 4, 32'h9212_A55A, 608, 1'b0};
    vecs[2] = '{1'b0, 8'h12, 16'hA55A,  1, 2, 32'h9012_0000, 320, 1'b1};
    vecs[3] = '{1'b1, 8'hFF, 16'h0000,  0, 1, 32'h9200_0000, 176, 1'b1};
    vecs[4] = '{1'b0, 8'h00, 16'hFFFF,  3, 4, 32'h9000_FFFF, 608, 1'b1};
    vecs[5] = '{1'b1, 8'h3C, 16'h0180, -1, 4, 32'h923C_0180, 608, 1'b0};

    #12;
    check("rst_scl_oe", 32'(scl_oe), 32'(0));
    check("rst_sda_oe", 32'(sda_oe), 32'(0));
    check("rst_cmd_ready", 32'(cmd_ready), 32'(1));
    check("rst_done", 32'(done), 32'(0));
    check("rst_nack_err", 32'(nack_err), 32'(0));
    @(negedge sysClk);
    rst_n = 1'b1;

    // First vector is accepted on the first rising edge after reset release.
    for (int i = 0; i < 6; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Back-to-back: cmd_valid stays high, second command taken on the done edge.
    @(negedge sysClk);
    cmd_cam_id = 1'b0; cmd_addr = 8'h55; cmd_data = 16'h1234; cmd_valid = 1'b1;
    @(posedge sysClk);
    b0 = rises; base = rises; nack_k = -1;
    #1;
    cmd_cam_id = 1'b1; cmd_addr = 8'hAA; cmd_data = 16'hBEEF;
    wait_done("b2b_first", 608);
    check("b2b_ready_at_done", 32'(cmd_ready), 32'(1));
    check_bytes("b2b_first", b0, 4, 32'h9055_1234);
    @(posedge sysClk);
    b0 = rises; base = rises;
    #1;
    cmd_valid = 1'b0;
    check("b2b_second_accepted", 32'(cmd_ready), 32'(0));
    check("b2b_start_q0", 32'({scl_oe, sda_oe}), 32'(2'b01));
    wait_done("b2b_second", 608);
    check_bytes("b2b_second", b0, 4, 32'h92AA_BEEF);
    @(posedge sysClk);
    #1;

    // Reset during the third byte while both lines are pulled low.
    accept(1'b0, 8'h12, 16'hA55A, -1);
    n = 0;
    while (!(rises >= base + 21 && scl_oe && sda_oe) && n < BUDGET) begin
      @(posedge sysClk);
      #1;
      n++;
    end
    check("rst_mid_reached", 32'(n < BUDGET), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_scl_oe", 32'(scl_oe), 32'(0));
    check("rst_mid_sda_oe", 32'(sda_oe), 32'(0));
    check("rst_mid_ready", 32'(cmd_ready), 32'(1));
    n = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge sysClk);
      #1;
      if (done) n++;
    end
    @(negedge sysClk);
    rst_n = 1'b1;
    for (int c = 0; c < 2 * CLK_DIV; c++) begin
      @(posedge sysClk);
      #1;
      if (done) n++;
    end
    check("rst_mid_no_done", 32'(n), 32'(0));
    check("rst_mid_lines_idle", 32'({scl_oe, sda_oe}), 32'(0));
    run_vec("after_rst", vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
